// File: rtl/k_sort_controller_if.sv
// Stream and sorter-bank bundle around the top-K sort controller.
// slave is the controller side; master is the environment side.
interface k_sort_controller_if #(
    parameter int NUM_CH    = 4,
    parameter int VAL_WIDTH = 32
);
    logic                        in_valid;
    logic                        in_ready;
    logic [VAL_WIDTH-1:0]        in_value;

    logic                        srt_reset;
    logic [NUM_CH-1:0]           srt_valid;
    logic [VAL_WIDTH-1:0]        srt_value;
    logic                        srt_done;
    logic [NUM_CH-1:0]           srt_outEn;
    logic [NUM_CH*32-1:0]        srt_name_in;
    logic [NUM_CH*VAL_WIDTH-1:0] srt_value_in;

    logic                        out_valid;
    logic                        out_ready;
    logic [31:0]                 out_name;
    logic [VAL_WIDTH-1:0]        out_value;
    logic                        out_last;

    modport slave (
        input  in_valid, in_value,
        output in_ready,
        output srt_reset, srt_valid, srt_value,
        output srt_done, srt_outEn,
        input  srt_name_in, srt_value_in,
        output out_valid, out_name, out_value, out_last,
        input  out_ready
    );

    modport master (
        output in_valid, in_value,
        input  in_ready,
        input  srt_reset, srt_valid, srt_value,
        input  srt_done, srt_outEn,
        output srt_name_in, srt_value_in,
        input  out_valid, out_name, out_value, out_last,
        output out_ready
    );
endinterface

// File: rtl/k_sort_controller.sv
// Query sequencer for a bank of top-K sorter channels: clear, deal the
// distance stream round-robin, then drain every channel in order.
module k_sort_controller #(
    parameter int NUM_CH    = 4,
    parameter int K         = 8,
    parameter int VAL_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] num_entries,
    output logic        busy,
    output logic        query_done,
    k_sort_controller_if.slave bus
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_OUTPUT,
        S_FIN
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [31:0]          r_remaining;
    logic [CW-1:0]        r_ch_ptr;
    logic [CW-1:0]        r_out_ch;
    logic [IW-1:0]        r_out_idx;

    logic                 w_in_ready;
    logic                 w_out_valid;
    logic                 w_clear;
    logic                 w_busy;
    logic                 w_fin;
    logic                 w_in_hs;
    logic                 w_out_hs;
    logic                 w_at_last;
    logic [NUM_CH-1:0]    w_srt_valid;
    logic [NUM_CH-1:0]    w_srt_outEn;
    logic [31:0]          w_name;
    logic [VAL_WIDTH-1:0] w_value;

    assign w_in_hs   = bus.in_valid & w_in_ready;
    assign w_out_hs  = w_out_valid & bus.out_ready;
    assign w_at_last = (r_out_ch == LAST_CH) && (r_out_idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_CLEAR;
            end
            S_CLEAR: begin
                w_next = (r_remaining == 32'd0) ? S_OUTPUT : S_LOAD;
            end
            S_LOAD: begin
                if (w_in_hs && (r_remaining == 32'd1)) w_next = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (w_out_hs && w_at_last) w_next = S_FIN;
            end
            S_FIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_clear     = 1'b0;
        w_busy      = 1'b0;
        w_fin       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
            end
            S_CLEAR: begin
                w_clear = 1'b1;
                w_busy  = 1'b1;
            end
            S_LOAD: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
            end
            S_OUTPUT: begin
                w_out_valid = 1'b1;
                w_busy      = 1'b1;
            end
            S_FIN: begin
                w_fin = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Counters; remaining is only latched from IDLE so a start mid-query is ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_remaining <= 32'd0;
            r_ch_ptr    <= '0;
            r_out_ch    <= '0;
            r_out_idx   <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_remaining <= num_entries;
            end
            if (w_clear) begin
                r_ch_ptr  <= '0;
                r_out_ch  <= '0;
                r_out_idx <= '0;
            end
            if (w_in_hs) begin
                r_remaining <= r_remaining - 32'd1;
                r_ch_ptr    <= (r_ch_ptr == LAST_CH) ? '0 : r_ch_ptr + CW'(1);
            end
            if (w_out_hs) begin
                if (r_out_idx == LAST_IDX) begin
                    r_out_idx <= '0;
                    r_out_ch  <= r_out_ch + CW'(1);
                end else begin
                    r_out_idx <= r_out_idx + IW'(1);
                end
            end
        end
    end

    always_comb begin
        w_srt_valid = '0;
        w_srt_outEn = '0;
        w_name      = '0;
        w_value     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_in_hs && (r_ch_ptr == CW'(c))) begin
                w_srt_valid[c] = 1'b1;
            end
            if (r_out_ch == CW'(c)) begin
                w_srt_outEn[c] = w_out_hs;
                w_name         = bus.srt_name_in[32*c +: 32];
                w_value        = bus.srt_value_in[VAL_WIDTH*c +: VAL_WIDTH];
            end
        end
    end

    assign busy          = w_busy;
    assign query_done    = w_fin;
    assign bus.in_ready  = w_in_ready;
    assign bus.srt_reset = ~reset_n | w_clear;
    assign bus.srt_valid = w_srt_valid;
    assign bus.srt_value = bus.in_value;
    assign bus.srt_done  = w_out_valid;
    assign bus.srt_outEn = w_srt_outEn;
    assign bus.out_valid = w_out_valid;
    assign bus.out_name  = w_name;
    assign bus.out_value = w_value;
    assign bus.out_last  = w_out_valid & w_at_last;

endmodule

// File: tb/tb_k_sort_controller.sv
// Bench for k_sort_controller: sorter-bank model, reference top-K model,
// and a scoreboard monitor on the output stream.
module tb_k_sort_controller;

    localparam int NCH = 2;
    localparam int KK  = 2;
    localparam int VW  = 32;
    localparam logic [31:0]   SENT_N = 32'hFFFF_FFFF;
    localparam logic [VW-1:0] SENT_V = '1;

    typedef struct {
        logic [31:0]   name;
        logic [VW-1:0] value;
        bit            last;
    } res_t;

    typedef logic [VW-1:0] val_q_t[$];

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] num_entries = 32'd0;
    logic        busy;
    logic        query_done;

    k_sort_controller_if #(.NUM_CH(NCH), .VAL_WIDTH(VW)) bus ();

    k_sort_controller #(.NUM_CH(NCH), .K(KK), .VAL_WIDTH(VW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .num_entries (num_entries),
        .busy        (busy),
        .query_done  (query_done),
        .bus         (bus.slave)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    int   exp_num = 0;
    int   acc_cnt = 0;
    int   out_pos = 0;
    bit   hold_low = 0;
    bit   rand_rdy = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Sorter bank model: K smallest per channel, equal newcomer goes first.
    logic [31:0]   m_name[NCH][KK];
    logic [VW-1:0] m_val[NCH][KK];
    int            m_cnt[NCH];
    int            m_ptr[NCH];
    logic          s_rst = 1'b1;
    logic [NCH-1:0] s_wr = '0;
    logic [NCH-1:0] s_oe = '0;
    logic [VW-1:0]  s_v = '0;

    always @(negedge clk) begin
        s_rst <= bus.srt_reset;
        s_wr  <= bus.srt_valid;
        s_v   <= bus.srt_value;
        s_oe  <= bus.srt_outEn;
    end

    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (s_rst) begin
                m_cnt[c] = 0;
                m_ptr[c] = 0;
                for (int k = 0; k < KK; k++) begin
                    m_name[c][k] = SENT_N;
                    m_val[c][k]  = SENT_V;
                end
            end else begin
                if (s_wr[c]) begin
                    int p;
                    p = KK;
                    for (int i = 0; i < KK; i++)
                        if (p == KK && s_v <= m_val[c][i]) p = i;
                    if (p < KK) begin
                        for (int i = KK - 1; i > p; i--) begin
                            m_name[c][i] = m_name[c][i-1];
                            m_val[c][i]  = m_val[c][i-1];
                        end
                        m_name[c][p] = 32'(m_cnt[c] * NCH + c);
                        m_val[c][p]  = s_v;
                    end
                    m_cnt[c]++;
                end
                if (s_oe[c]) m_ptr[c]++;
            end
        end
    end

    always_comb begin
        bus.srt_name_in  = '0;
        bus.srt_value_in = '0;
        for (int c = 0; c < NCH; c++) begin
            if (m_ptr[c] < KK) begin
                bus.srt_name_in[32*c +: 32]  = m_name[c][m_ptr[c]];
                bus.srt_value_in[VW*c +: VW] = m_val[c][m_ptr[c]];
            end else begin
                bus.srt_name_in[32*c +: 32]  = SENT_N;
                bus.srt_value_in[VW*c +: VW] = SENT_V;
            end
        end
    end

    // Reference: entry n belongs to channel n mod NCH; per channel take the
    // K smallest (ties: larger n first), pad with sentinels, channel order.
    task automatic push_expected(input val_q_t vals);
        for (int c = 0; c < NCH; c++) begin
            int ns[$];
            bit used[$];
            for (int n = 0; n < vals.size(); n++)
                if (n % NCH == c) begin
                    ns.push_back(n);
                    used.push_back(1'b0);
                end
            for (int k = 0; k < KK; k++) begin
                int   best;
                res_t r;
                best = -1;
                for (int j = 0; j < ns.size(); j++) begin
                    if (used[j]) continue;
                    if (best < 0 || vals[ns[j]] < vals[ns[best]] ||
                        (vals[ns[j]] == vals[ns[best]] && ns[j] > ns[best]))
                        best = j;
                end
                if (best < 0) begin
                    r.name  = SENT_N;
                    r.value = SENT_V;
                end else begin
                    used[best] = 1'b1;
                    r.name  = 32'(ns[best]);
                    r.value = vals[ns[best]];
                end
                r.last = (c == NCH - 1) && (k == KK - 1);
                exp_q.push_back(r);
            end
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (hold_low) bus.out_ready = 1'b0;
        else if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
        else bus.out_ready = 1'b1;
    end

    // Scoreboard monitor
    bit            held = 0;
    bit            done_due = 0;
    logic [31:0]   h_name;
    logic [VW-1:0] h_value;
    logic          h_last;

    always @(negedge clk) begin
        if (!reset_n) begin
            held     = 0;
            done_due = 0;
        end else begin
            if (done_due || query_done)
                chk("query_done_after_last", 64'(query_done), 64'(done_due));
            if (query_done) begin
                chk("accepted_count", 64'(acc_cnt), 64'(exp_num));
                chk("busy_low_in_done", 64'(busy), 64'd0);
                acc_cnt = 0;
                out_pos = 0;
            end
            done_due = 0;
            if (bus.in_valid && bus.in_ready) begin
                chk("srt_valid", 64'(bus.srt_valid), 64'(NCH'(1) << (acc_cnt % NCH)));
                chk("srt_value", 64'(bus.srt_value), 64'(bus.in_value));
                acc_cnt++;
            end
            if (bus.out_valid && !bus.out_ready) begin
                chk("outEn_in_stall", 64'(bus.srt_outEn), 64'd0);
                if (held) begin
                    chk("stall_name", 64'(bus.out_name), 64'(h_name));
                    chk("stall_value", 64'(bus.out_value), 64'(h_value));
                    chk("stall_last", 64'(bus.out_last), 64'(h_last));
                end
                held    = 1;
                h_name  = bus.out_name;
                h_value = bus.out_value;
                h_last  = bus.out_last;
            end else begin
                held = 0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'd1, 64'd0);
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    chk("out_name", 64'(bus.out_name), 64'(r.name));
                    chk("out_value", 64'(bus.out_value), 64'(r.value));
                    chk("out_last", 64'(bus.out_last), 64'(r.last));
                    chk("srt_outEn", 64'(bus.srt_outEn), 64'(NCH'(1) << (out_pos / KK)));
                    chk("srt_done", 64'(bus.srt_done), 64'd1);
                    done_due = r.last;
                    out_pos++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input int n);
        start       = 1'b1;
        num_entries = 32'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input val_q_t vals, input int from, input int to, input bit junk);
        for (int i = from; i < to; i++) begin
            int  w;
            bit  ok;
            if (rand_rdy && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                tick();
            end
            bus.in_valid = 1'b1;
            bus.in_value = vals[i];
            w  = 0;
            ok = 0;
            while (!ok && w < 200) begin
                @(negedge clk);
                ok = bus.in_ready;
                tick();
                w++;
            end
            if (!ok) chk("in_ready_timeout", 64'd0, 64'd1);
        end
        if (junk) begin
            bus.in_valid = 1'b1;
            bus.in_value = 32'hDEAD_BEEF;
            repeat (3) tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int w;
        bit seen;
        w    = 0;
        seen = 0;
        while (!seen && w < 1000) begin
            @(negedge clk);
            seen = query_done;
            tick();
            w++;
        end
        chk("done_timeout", 64'(seen), 64'd1);
    endtask

    task automatic run_query(input val_q_t vals);
        exp_num = vals.size();
        push_expected(vals);
        issue_start(vals.size());
        feed(vals, 0, vals.size(), 1'b1);
        wait_done();
    endtask

    initial begin
        val_q_t v;
        bus.in_valid  = 1'b0;
        bus.in_value  = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_query_done", 64'(query_done), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_srt_reset", 64'(bus.srt_reset), 64'd1);
        chk("rst_srt_valid", 64'(bus.srt_valid), 64'd0);
        chk("rst_srt_done", 64'(bus.srt_done), 64'd0);
        chk("rst_srt_outEn", 64'(bus.srt_outEn), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        chk("idle_srt_reset", 64'(bus.srt_reset), 64'd0);
        tick();

        v = '{5, 3, 9, 1, 7, 2};
        run_query(v);

        v = '{4, 8, 6};
        run_query(v);

        v = {};
        run_query(v);

        v = '{11, 2, 2, 7, 0, 2};
        exp_num = 6;
        push_expected(v);
        issue_start(6);
        feed(v, 0, 6, 1'b0);
        begin
            int w;
            w = 0;
            while (!bus.out_valid && w < 50) begin
                tick();
                w++;
            end
            chk("out_valid_timeout", 64'(bus.out_valid), 64'd1);
        end
        tick();
        hold_low = 1;
        repeat (6) tick();
        hold_low = 0;
        wait_done();

        v = '{6, 1, 6, 3, 1, 0};
        exp_num = 6;
        push_expected(v);
        issue_start(6);
        feed(v, 0, 2, 1'b0);
        start       = 1'b1;
        num_entries = 32'd2;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("busy_in_load", 64'(busy), 64'd1);
        tick();
        feed(v, 2, 6, 1'b1);
        wait_done();

        v = '{9, 9, 9, 9, 9, 9};
        exp_num = 6;
        issue_start(6);
        feed(v, 0, 2, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_srt_reset", 64'(bus.srt_reset), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
        acc_cnt = 0;
        out_pos = 0;
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        tick();
        v = '{3, 12, 1, 4, 8, 0};
        run_query(v);

        rand_rdy = 1;
        for (int q = 0; q < 12; q++) begin
            int n;
            n = $urandom_range(0, 9);
            v = {};
            for (int i = 0; i < n; i++) v.push_back(VW'($urandom_range(0, 15)));
            run_query(v);
        end
        rand_rdy = 0;
        repeat (3) tick();

        chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
